// File: rtl/sb_pkg.sv
// Shared types and sizing for the posted-write store buffer.
// Entry widths are fixed here; store_buffer's DEPTH/AW/DW default to these.
package sb_pkg;

   localparam int SB_DEPTH = 4;
   localparam int SB_AW    = 32;
   localparam int SB_DW    = 32;

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // One buffered store: word address (byte offset dropped) and data.
   typedef struct packed {
      logic [SB_AW-3:0] addr;
      logic [SB_DW-1:0] data;
   } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector for load forwarding.
// Age 0 is the entry at tail-1 (most recent store); age DEPTH-1 is the oldest slot.
module sb_fwd_match
   import sb_pkg::*;
(
   input  sb_entry_t            entries [SB_DEPTH],
   input  logic [SB_DEPTH-1:0]  valid,
   input  logic [PTR_W-1:0]     tail,
   input  logic [SB_AW-3:0]     addr,
   output logic                 hit,
   output logic [SB_DW-1:0]     data
);

   logic [PTR_W-1:0]    age_idx [SB_DEPTH];
   logic [SB_DEPTH-1:0] age_match;

   // Map each age to its slot and flag valid entries with a matching word address.
   generate
      for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_age
         assign age_idx[gi]   = tail - PTR_W'(gi + 1);
         assign age_match[gi] = valid[age_idx[gi]] && (entries[age_idx[gi]].addr == addr);
      end
   endgenerate

   // Walk from oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int k = SB_DEPTH - 1; k >= 0; k--) begin
         if (age_match[k]) begin
            hit  = 1'b1;
            data = entries[age_idx[k]].data;
         end
      end
   end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the core's data port and a slow,
// handshaked data memory. Stores retire into a circular FIFO and drain in
// order; loads forward from the youngest buffered store to the same word.
// Optional: define STORE_COALESCE_EN to merge a store into the youngest
// entry when it targets the same word (and that entry is not the head
// currently being offered to memory).
module store_buffer
   import sb_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          memwrite,
   input  logic          memread,
   input  logic [AW-1:0] dataadr,
   input  logic [DW-1:0] writedata,
   output logic [DW-1:0] readdata,
   output logic          stall,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ready,
   output logic [AW-1:0] mem_raddr,
   input  logic [DW-1:0] mem_rdata,
   output logic          empty
);

   sb_entry_t            entries_reg [SB_DEPTH];
   logic [SB_DEPTH-1:0]  valid_reg;
   logic [PTR_W-1:0]     head_reg;
   logic [PTR_W-1:0]     tail_reg;
   logic [CNT_W-1:0]     count_reg;

   logic [PTR_W-1:0]     youngest_idx;
   logic                 full;
   logic                 coalesce_hit;
   logic                 alloc;
   logic                 pop;
   logic                 fwd_hit;
   logic [DW-1:0]        fwd_data;
   logic                 unused_bits;

   assign youngest_idx = tail_reg - PTR_W'(1);
   assign full         = (count_reg == CNT_W'(DEPTH));
   assign empty        = (count_reg == '0);
   assign mem_we       = !empty;
   assign mem_addr     = {entries_reg[head_reg].addr, 2'b00};
   assign mem_wdata    = entries_reg[head_reg].data;
   assign mem_raddr    = dataadr;

`ifdef STORE_COALESCE_EN
   // Merge into the youngest entry unless it is the head being offered to memory.
   assign coalesce_hit = memwrite && valid_reg[youngest_idx]
                         && (entries_reg[youngest_idx].addr == dataadr[AW-1:2])
                         && !((youngest_idx == head_reg) && mem_we);
`else
   assign coalesce_hit = 1'b0;
`endif

   // Stall depends only on registered occupancy, never on mem_ready.
   assign stall = memwrite && full && !coalesce_hit;
   assign alloc = memwrite && !stall && !coalesce_hit;
   assign pop   = mem_we && mem_ready;

   // Loads are not qualified by memread; the byte offset is not used for matching.
   assign unused_bits = ^{memread, dataadr[1:0]};

   // Pointers, occupancy and per-slot valid bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         valid_reg <= '0;
      end else begin
         if (pop) begin
            head_reg            <= head_reg + PTR_W'(1);
            valid_reg[head_reg] <= 1'b0;
         end
         if (alloc) begin
            tail_reg            <= tail_reg + PTR_W'(1);
            valid_reg[tail_reg] <= 1'b1;
         end
         count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(pop);
      end
   end

   // Entry storage; contents are don't-care after reset so no reset term.
   always_ff @(posedge clk) begin
      if (alloc) begin
         entries_reg[tail_reg] <= '{addr: dataadr[AW-1:2], data: writedata};
      end else if (coalesce_hit) begin
         entries_reg[youngest_idx].data <= writedata;
      end
   end

   sb_fwd_match u_fwd (
      .entries (entries_reg),
      .valid   (valid_reg),
      .tail    (tail_reg),
      .addr    (dataadr[AW-1:2]),
      .hit     (fwd_hit),
      .data    (fwd_data)
   );

   // Forwarded data beats the memory read port.
   always_comb begin
      readdata = fwd_hit ? fwd_data : mem_rdata;
   end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue of pending stores is the
// reference model; a negedge monitor checks drains, loads and stall.
module tb_store_buffer;

   localparam int DEPTH = 4;
`ifdef STORE_COALESCE_EN
   localparam bit COAL = 1'b1;
`else
   localparam bit COAL = 1'b0;
`endif

   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
   } ment_t;

   logic        clk = 1'b0;
   logic        reset, memwrite, memread, mem_ready;
   logic [31:0] dataadr, writedata, mem_rdata;
   logic [31:0] readdata, mem_addr, mem_wdata, mem_raddr;
   logic        stall, mem_we, empty;

   ment_t       q[$];
   logic [31:0] lq[$];
   logic        exp_stall = 1'b0;
   int          n_checks = 0;
   int          n_fail = 0;
   int          drains = 0;

   always #5 clk = ~clk;

   store_buffer dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .memread(memread),
      .dataadr(dataadr), .writedata(writedata), .readdata(readdata),
      .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .empty(empty)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // One core cycle: drive inputs, predict, then commit the model at the edge.
   task automatic step(input logic we, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy, input logic rst);
      logic        coal;
      logic [31:0] lexp;
      reset = rst; memwrite = we; memread = rd; dataadr = a; writedata = d;
      mem_ready = rdy; mem_rdata = $urandom;
      coal = COAL && we && !rst && (q.size() >= 2) && (q[q.size()-1].a == a[31:2]);
      exp_stall = we && !rst && (q.size() == DEPTH) && !coal;
      if (rd && !rst) begin
         lexp = mem_rdata;
         for (int i = 0; i < q.size(); i++)
            if (q[i].a == a[31:2]) lexp = q[i].d;
         lq.push_back(lexp);
      end
      @(posedge clk);
      if (rst) q.delete();
      else if (we && !exp_stall) begin
         if (coal) q[q.size()-1].d = d;
         else q.push_back('{a: a[31:2], d: d});
      end
      $display("cyc we=%0b rd=%0b adr=%0d wd=%0d rdy=%0b rst=%0b stall_exp=%0b pend=%0d",
               we, rd, a, d, rdy, rst, exp_stall, q.size());
      #1;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, 32'd0, 32'd0, rdy, 1'b0);
   endtask

   task automatic drain_all();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         idle(1'b1);
         n++;
      end
      chk("drain_timeout_pending", q.size(), 0);
      chk("drained_empty", empty, 1);
   endtask

   // Monitor: checks status, forwarded loads and each accepted drain.
   always @(negedge clk) begin
      if (memread && memwrite) begin
         n_checks++; n_fail++;
         $display("FAIL illegal_load_and_store actual=1 expected=0");
      end
      if (!reset) begin
         chk("stall", stall, exp_stall);
         chk("empty", empty, q.size() == 0);
         chk("mem_we", mem_we, q.size() != 0);
         if (memread) begin
            if (lq.size() == 0) chk("load_unexpected", 1, 0);
            else chk("readdata", readdata, lq.pop_front());
         end
         if (mem_we && mem_ready) begin
            if (q.size() == 0) chk("drain_unexpected", 1, 0);
            else begin
               chk("drain_addr", mem_addr, {q[0].a, 2'b00});
               chk("drain_data", mem_wdata, q[0].d);
               void'(q.pop_front());
            end
            drains++;
         end
      end
   end

   initial begin
      int d0;
      logic pend_we;
      logic [31:0] pa, pd;

      // Reset, then idle with a load: pass-through from the read port.
      step(0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 1, 1);
      step(0, 1, 32'd40, 0, 1, 0);
      chk("rst_empty", empty, 1);
      chk("rst_mem_we", mem_we, 0);

      // Single store then forwarded load.
      step(1, 0, 32'd84, 32'd666, 0, 0);
      chk("st84_mem_we", mem_we, 1);
      chk("st84_mem_addr", mem_addr, 84);
      chk("st84_mem_wdata", mem_wdata, 666);
      chk("st84_empty", empty, 0);
      step(0, 1, 32'd84, 0, 0, 0);
      drain_all();

      // Fill, stall on the fifth, one ready pulse, then accepted.
      d0 = drains;
      for (int i = 0; i < 4; i++) step(1, 0, 32'(4 * i), 32'(i + 1), 0, 0);
      step(1, 0, 32'd16, 32'd5, 0, 0);
      chk("full_stall", stall, 1);
      step(1, 0, 32'd16, 32'd5, 1, 0);
      step(1, 0, 32'd16, 32'd5, 0, 0);
      chk("fifth_accept_pending", mem_we, 1);
      drain_all();
      chk("fill_drain_count", drains - d0, 5);

      // Same-word stores behind an older entry: last value wins.
      d0 = drains;
      step(1, 0, 32'd0, 32'd1, 0, 0);
      step(1, 0, 32'd80, 32'd7, 0, 0);
      step(1, 0, 32'd80, 32'd9, 0, 0);
      step(0, 1, 32'd80, 0, 0, 0);
      drain_all();
      chk("same_word_drain_count", drains - d0, COAL ? 2 : 3);

      // Pointer wrap: ten back-to-back stores with memory always ready.
      d0 = drains;
      for (int i = 0; i < 10; i++) step(1, 0, 32'(100 + 4 * i), 32'(1000 + i), 1, 0);
      drain_all();
      chk("wrap_drain_count", drains - d0, 10);

      // Reset with pending stores discards them.
      for (int i = 0; i < 3; i++) step(1, 0, 32'(200 + 4 * i), 32'(i + 50), 0, 0);
      d0 = drains;
      step(0, 0, 0, 0, 0, 1);
      chk("rst_mid_mem_we", mem_we, 0);
      chk("rst_mid_empty", empty, 1);
      for (int i = 0; i < 5; i++) idle(1'b1);
      chk("rst_mid_no_drains", drains - d0, 0);

      // Randomized mix over a small address set so forwarding hits often.
      pend_we = 1'b0; pa = 0; pd = 0;
      for (int i = 0; i < 400; i++) begin
         if (!pend_we) begin
            pend_we = ($urandom_range(0, 2) != 0);
            pa = 32'($urandom_range(0, 5) * 4);
            pd = $urandom;
         end
         if (pend_we) step(1, 0, pa, pd, 1'($urandom_range(0, 3) == 0), 0);
         else step(0, 1'($urandom_range(0, 1)), pa, 0, 1'($urandom_range(0, 3) == 0), 0);
         if (pend_we && !exp_stall) pend_we = 1'b0;
      end
      drain_all();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
